pc_gen_unit: RTL and testbench

Parametrised program-counter generator for the RISC-V core, succeeding the plain combinational `pc + imm` target adder. Holds the architectural PC register and computes the next PC for sequential fetch, `branch`/`jal`, `jalr` and predicted returns. It adds stall hold, a circular return-address stack (RAS) and misaligned-target trapping with a two-state controller. Sits between the control unit/ALU and the instruction memory address port.

---
 rtl/pc_gen_unit.sv | 161 ++++++++++++++++
 tb/tb_pc_gen_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
// Program-counter generator: architectural PC, next-PC selection, circular
// return-address stack and a RUN/TRAP controller for misaligned targets.
module pc_gen_unit #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            stall,
    input  logic [1:0]      pcSrc,
    input  logic [XLEN-1:0] immExt,
    input  logic [XLEN-1:0] rs1Val,
    input  logic            rasPush,
    input  logic [XLEN-1:0] trapVec,
    input  logic            trapAck,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcPlus4,
    output logic [XLEN-1:0] pcTarget,
    output logic            rasEmpty,
    output logic            misaligned,
    output logic [XLEN-1:0] badAddr
);

    localparam int PTR_W = $clog2(RAS_DEPTH);

    localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(3'd4);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1'b1);
    localparam logic [PTR_W:0]   CNT_ZERO  = (PTR_W+1)'(1'b0);
    localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(RAS_DEPTH);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    state_t            state_r;
    logic [XLEN-1:0]   pc_r;
    logic              misaligned_r;
    logic [XLEN-1:0]   bad_addr_r;
    logic [XLEN-1:0]   ras_mem_r [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_top_r;
    logic [PTR_W:0]    ras_count_r;

    logic [XLEN-1:0]   pc_plus4_s;
    logic [XLEN-1:0]   pc_target_s;
    logic [XLEN-1:0]   jalr_sum_s;
    logic [XLEN-1:0]   ras_top_val_s;
    logic              ras_nonempty_s;
    logic              pop_s;
    logic              push_s;
    logic [XLEN-1:0]   next_pc_s;
    logic              advance_s;
    logic              fault_s;

    // Combinational address arithmetic; all sums wrap modulo 2^XLEN.
    always_comb begin
        pc_plus4_s     = pc_r + PC_STEP;
        pc_target_s    = pc_r + immExt;
        jalr_sum_s     = rs1Val + immExt;
        ras_nonempty_s = (ras_count_r != CNT_ZERO);
        ras_top_val_s  = ras_mem_r[ras_top_r];
        pop_s          = (pcSrc == 2'b11) && ras_nonempty_s;
        push_s         = rasPush;
    end

    // Candidate next PC; a return with an empty stack falls through to pc+4.
    always_comb begin
        next_pc_s = pc_plus4_s;
        case (pcSrc)
            2'b00:   next_pc_s = pc_plus4_s;
            2'b01:   next_pc_s = pc_target_s;
            2'b10:   next_pc_s = {jalr_sum_s[XLEN-1:1], 1'b0};
            2'b11:   next_pc_s = ras_nonempty_s ? ras_top_val_s : pc_plus4_s;
            default: next_pc_s = pc_plus4_s;
        endcase
    end

    // Decide whether this cycle advances the PC or raises a misaligned trap.
    always_comb begin
        advance_s = 1'b0;
        fault_s   = 1'b0;
        if ((state_r == ST_RUN) && !stall) begin
            advance_s = (next_pc_s[1:0] == 2'b00);
            fault_s   = (next_pc_s[1:0] != 2'b00);
        end else begin
            advance_s = 1'b0;
            fault_s   = 1'b0;
        end
    end

    // RUN/TRAP controller with PC, trap outputs and stack pointers.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r      <= ST_RUN;
            pc_r         <= RESET_VECTOR;
            misaligned_r <= 1'b0;
            bad_addr_r   <= {XLEN{1'b0}};
            ras_top_r    <= {PTR_W{1'b0}};
            ras_count_r  <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (advance_s) begin
                        pc_r <= next_pc_s;
                        if (push_s && !pop_s) begin
                            ras_top_r   <= ras_top_r + PTR_ONE;
                            ras_count_r <= (ras_count_r == CNT_FULL) ? CNT_FULL
                                                                     : ras_count_r + CNT_ONE;
                        end else if (pop_s && !push_s) begin
                            ras_top_r   <= ras_top_r - PTR_ONE;
                            ras_count_r <= ras_count_r - CNT_ONE;
                        end else begin
                            ras_top_r   <= ras_top_r;
                            ras_count_r <= ras_count_r;
                        end
                    end else if (fault_s) begin
                        state_r      <= ST_TRAP;
                        misaligned_r <= 1'b1;
                        bad_addr_r   <= next_pc_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                ST_TRAP: begin
                    if (trapAck) begin
                        state_r      <= ST_RUN;
                        pc_r         <= trapVec;
                        misaligned_r <= 1'b0;
                    end else begin
                        state_r <= ST_TRAP;
                    end
                end
                default: begin
                    state_r      <= ST_RUN;
                    misaligned_r <= 1'b0;
                end
            endcase
        end
    end

    // Stack storage; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (resetN && advance_s && push_s) begin
            if (pop_s) begin
                ras_mem_r[ras_top_r] <= pc_plus4_s;
            end else begin
                ras_mem_r[ras_top_r + PTR_ONE] <= pc_plus4_s;
            end
        end
    end

    assign pc         = pc_r;
    assign pcPlus4    = pc_plus4_s;
    assign pcTarget   = pc_target_s;
    assign rasEmpty   = ~ras_nonempty_s;
    assign misaligned = misaligned_r;
    assign badAddr    = bad_addr_r;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed, table-driven bench for pc_gen_unit with hand-computed expectations.
module tb_pc_gen_unit;

    logic        clk;
    logic        resetN;
    logic        stall;
    logic [1:0]  pcSrc;
    logic [31:0] immExt;
    logic [31:0] rs1Val;
    logic        rasPush;
    logic [31:0] trapVec;
    logic        trapAck;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [31:0] pcTarget;
    logic        rasEmpty;
    logic        misaligned;
    logic [31:0] badAddr;

    int n_chk;
    int n_fail;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        push;
        logic [31:0] tvec;
        logic        tack;
        logic [31:0] e_pc;
        logic        e_mis;
        logic [31:0] e_bad;
        logic        e_emp;
    } vec_t;

    vec_t tbl[$];

    pc_gen_unit #(
        .XLEN(32),
        .RESET_VECTOR(32'h0000_0000),
        .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .stall(stall),
        .pcSrc(pcSrc),
        .immExt(immExt),
        .rs1Val(rs1Val),
        .rasPush(rasPush),
        .trapVec(trapVec),
        .trapAck(trapAck),
        .pc(pc),
        .pcPlus4(pcPlus4),
        .pcTarget(pcTarget),
        .rasEmpty(rasEmpty),
        .misaligned(misaligned),
        .badAddr(badAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic rst_n, input logic stl, input logic [1:0] src,
                                input logic [31:0] imm, input logic [31:0] rs1,
                                input logic push, input logic [31:0] tvec, input logic tack,
                                input logic [31:0] e_pc, input logic e_mis,
                                input logic [31:0] e_bad, input logic e_emp);
        vec_t v;
        v.rst_n = rst_n; v.stall = stl;  v.src  = src;  v.imm   = imm;   v.rs1   = rs1;
        v.push  = push;  v.tvec  = tvec; v.tack = tack; v.e_pc  = e_pc;  v.e_mis = e_mis;
        v.e_bad = e_bad; v.e_emp = e_emp;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [31:0] prev_pc;
        n_chk   = 0;
        n_fail  = 0;
        prev_pc = 32'h0;
        resetN  = 1'b0;
        stall   = 1'b0;
        pcSrc   = 2'b00;
        immExt  = 32'h0;
        rs1Val  = 32'h0;
        rasPush = 1'b0;
        trapVec = 32'h0;
        trapAck = 1'b0;

        //  rst  stl src   imm           rs1           psh  tvec          ack   pc            mis  bad           emp
        add(1'b0,1'b0,2'd0,32'h0,        32'h0,        1'b0,32'h0,        1'b0, 32'h0000_0000,1'b0,32'h0,        1'b1);
        add(1'b1,1'b0,2'd0,32'h0,        32'h0,        1'b0,32'h0,        1'b0, 32'h0000_0004,1'b0,32'h0,        1'b1);
        add(1'b1,1'b0,2'd0,32'h0,        32'h0,        1'b0,32'h0,        1'b0, 32'h0000_0008,1'b0,32'h0,        1'b1);
        add(1'b1,1'b0,2'd0,32'h0,        32'h0,        1'b0,32'h0,        1'b0, 32'h0000_000C,1'b0,32'h0,        1'b1);
        add(1'b1,1'b1,2'd0,32'h0,        32'h0,        1'b0,32'h0,        1'b0, 32'h0000_000C,1'b0,32'h0,        1'b1);
        add(1'b1,1'b1,2'd0,32'h0,        32'h0,        1'b0,32'h0,        1'b0, 32'h0000_000C,1'b0,32'h0,        1'b1);
        // Backward branch from 0x100, then wrap past the top of the address space.
        add(1'b1,1'b0,2'd2,32'h0,        32'h0000_0100,1'b0,32'h0,        1'b0, 32'h0000_0100,1'b0,32'h0,        1'b1);
        add(1'b1,1'b0,2'd1,32'hFFFF_FFF0,32'h0,        1'b0,32'h0,        1'b0, 32'h0000_00F0,1'b0,32'h0,        1'b1);
        add(1'b1,1'b0,2'd2,32'h0,        32'hFFFF_FFFC,1'b0,32'h0,        1'b0, 32'hFFFF_FFFC,1'b0,32'h0,        1'b1);
        add(1'b1,1'b0,2'd0,32'h0,        32'h0,        1'b0,32'h0,        1'b0, 32'h0000_0000,1'b0,32'h0,        1'b1);
        // jalr to 0x203 clears bit 0 -> 0x202, still misaligned: trap, pc holds.
        add(1'b1,1'b0,2'd2,32'h0,        32'h0000_0203,1'b0,32'h0,        1'b0, 32'h0000_0000,1'b1,32'h0000_0202,1'b1);
        add(1'b1,1'b1,2'd0,32'h0,        32'h0,        1'b0,32'h0,        1'b0, 32'h0000_0000,1'b1,32'h0000_0202,1'b1);
        add(1'b1,1'b0,2'd0,32'h0,        32'h0,        1'b0,32'h0,        1'b0, 32'h0000_0000,1'b1,32'h0000_0202,1'b1);
        add(1'b1,1'b1,2'd0,32'h0,        32'h0,        1'b0,32'h0000_0080,1'b1, 32'h0000_0080,1'b0,32'h0000_0202,1'b1);
        add(1'b1,1'b0,2'd0,32'h0,        32'h0,        1'b0,32'h0000_0300,1'b1, 32'h0000_0084,1'b0,32'h0000_0202,1'b1);
        // Five calls into a four-deep stack, then five returns.
        add(1'b1,1'b0,2'd2,32'h0,        32'h0000_0010,1'b0,32'h0,        1'b0, 32'h0000_0010,1'b0,32'h0000_0202,1'b1);
        add(1'b1,1'b0,2'd2,32'h0,        32'h0000_0020,1'b1,32'h0,        1'b0, 32'h0000_0020,1'b0,32'h0000_0202,1'b0);
        add(1'b1,1'b0,2'd2,32'h0,        32'h0000_0030,1'b1,32'h0,        1'b0, 32'h0000_0030,1'b0,32'h0000_0202,1'b0);
        add(1'b1,1'b0,2'd2,32'h0,        32'h0000_0040,1'b1,32'h0,        1'b0, 32'h0000_0040,1'b0,32'h0000_0202,1'b0);
        add(1'b1,1'b0,2'd2,32'h0,        32'h0000_0050,1'b1,32'h0,        1'b0, 32'h0000_0050,1'b0,32'h0000_0202,1'b0);
        add(1'b1,1'b0,2'd2,32'h0,        32'h0000_0100,1'b1,32'h0,        1'b0, 32'h0000_0100,1'b0,32'h0000_0202,1'b0);
        add(1'b1,1'b0,2'd3,32'h0,        32'h0,        1'b0,32'h0,        1'b0, 32'h0000_0054,1'b0,32'h0000_0202,1'b0);
        add(1'b1,1'b0,2'd3,32'h0,        32'h0,        1'b0,32'h0,        1'b0, 32'h0000_0044,1'b0,32'h0000_0202,1'b0);
        add(1'b1,1'b0,2'd3,32'h0,        32'h0,        1'b0,32'h0,        1'b0, 32'h0000_0034,1'b0,32'h0000_0202,1'b0);
        add(1'b1,1'b0,2'd3,32'h0,        32'h0,        1'b0,32'h0,        1'b0, 32'h0000_0024,1'b0,32'h0000_0202,1'b1);
        add(1'b1,1'b0,2'd3,32'h0,        32'h0,        1'b0,32'h0,        1'b0, 32'h0000_0028,1'b0,32'h0000_0202,1'b1);
        // Push+pop with top 0x44 at pc 0x90, then a stalled push.
        add(1'b1,1'b0,2'd2,32'h0,        32'h0000_0040,1'b0,32'h0,        1'b0, 32'h0000_0040,1'b0,32'h0000_0202,1'b1);
        add(1'b1,1'b0,2'd2,32'h0,        32'h0000_0090,1'b1,32'h0,        1'b0, 32'h0000_0090,1'b0,32'h0000_0202,1'b0);
        add(1'b1,1'b0,2'd3,32'h0,        32'h0,        1'b1,32'h0,        1'b0, 32'h0000_0044,1'b0,32'h0000_0202,1'b0);
        add(1'b1,1'b1,2'd3,32'h0,        32'h0,        1'b1,32'h0,        1'b0, 32'h0000_0044,1'b0,32'h0000_0202,1'b0);
        add(1'b1,1'b0,2'd3,32'h0,        32'h0,        1'b0,32'h0,        1'b0, 32'h0000_0094,1'b0,32'h0000_0202,1'b1);
        add(1'b1,1'b0,2'd3,32'h0,        32'h0,        1'b0,32'h0,        1'b0, 32'h0000_0098,1'b0,32'h0000_0202,1'b1);
        // Enter TRAP with a non-empty stack, then reset out of it.
        add(1'b1,1'b0,2'd2,32'h0,        32'h0000_0200,1'b1,32'h0,        1'b0, 32'h0000_0200,1'b0,32'h0000_0202,1'b0);
        add(1'b1,1'b0,2'd2,32'h0,        32'h0000_0203,1'b0,32'h0,        1'b0, 32'h0000_0200,1'b1,32'h0000_0202,1'b0);
        add(1'b0,1'b0,2'd0,32'h0,        32'h0,        1'b0,32'h0,        1'b0, 32'h0000_0000,1'b0,32'h0,        1'b1);
        add(1'b1,1'b0,2'd0,32'h0,        32'h0,        1'b0,32'h0,        1'b0, 32'h0000_0004,1'b0,32'h0,        1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            resetN  = tbl[i].rst_n;
            stall   = tbl[i].stall;
            pcSrc   = tbl[i].src;
            immExt  = tbl[i].imm;
            rs1Val  = tbl[i].rs1;
            rasPush = tbl[i].push;
            trapVec = tbl[i].tvec;
            trapAck = tbl[i].tack;
            #1;
            if (i > 0) begin
                chk($sformatf("v%0d_pcPlus4", i), pcPlus4, prev_pc + 32'd4);
                chk($sformatf("v%0d_pcTarget", i), pcTarget, prev_pc + tbl[i].imm);
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("v%0d_misaligned", i), {31'd0, misaligned}, {31'd0, tbl[i].e_mis});
            chk($sformatf("v%0d_badAddr", i), badAddr, tbl[i].e_bad);
            chk($sformatf("v%0d_rasEmpty", i), {31'd0, rasEmpty}, {31'd0, tbl[i].e_emp});
            prev_pc = tbl[i].e_pc;
        end

        // trapAck must only reach pc through the register, one cycle later.
        @(negedge clk);
        pcSrc   = 2'b10;
        rs1Val  = 32'h0000_0007;
        immExt  = 32'h0;
        trapAck = 1'b0;
        @(posedge clk);
        #1;
        chk("seq_trap_pc_hold", pc, 32'h0000_0004);
        chk("seq_trap_mis", {31'd0, misaligned}, 32'd1);
        chk("seq_trap_bad", badAddr, 32'h0000_0006);
        @(negedge clk);
        pcSrc   = 2'b00;
        trapAck = 1'b1;
        trapVec = 32'h0000_0400;
        #1;
        chk("seq_ack_no_comb_path", pc, 32'h0000_0004);
        @(posedge clk);
        #1;
        chk("seq_ack_pc", pc, 32'h0000_0400);
        chk("seq_ack_mis", {31'd0, misaligned}, 32'd0);
        chk("seq_ack_bad_held", badAddr, 32'h0000_0006);
        @(negedge clk);
        trapAck = 1'b0;
        @(posedge clk);
        #1;
        chk("seq_after_ack_run", pc, 32'h0000_0404);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
